// File: rtl/jtcps1_fbrd_pkg.sv
// Shared types and constants for the CPS1 frame-buffer line reader.
// Build option: define JTCPS1_FBRD_STATS_EN to include the underrun counter.
package jtcps1_fbrd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int LINE_W_DEF = 384;
  localparam int PXL_W      = 9;
  localparam int COL_W      = 9;

endpackage

// File: rtl/jtcps1_fbrd_linebuf.sv
// Two line banks in one simple dual-port RAM: bank 0 at [0, LINE_W), bank 1 at
// [LINE_W, 2*LINE_W). The read port is registered and advances only on rd_cen.
module jtcps1_fbrd_linebuf
  import jtcps1_fbrd_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic             clk,
  input  logic             wr_bank,
  input  logic [COL_W-1:0] wr_col,
  input  logic [PXL_W-1:0] wr_data,
  input  logic             we,
  input  logic             rd_bank,
  input  logic [COL_W-1:0] rd_addr,
  input  logic             rd_cen,
  output logic [PXL_W-1:0] rd_data
);

  localparam int IW = $clog2(2 * LINE_W);

  logic [PXL_W-1:0] mem [0:2*LINE_W-1];
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;

  always_comb begin
    wr_idx = wr_bank ? IW'(LINE_W) + IW'(wr_col) : IW'(wr_col);
    rd_idx = rd_bank ? IW'(LINE_W) + IW'(rd_addr) : IW'(rd_addr);
  end

  // No reset on the array or its read register so the RAM maps onto block memory.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_cen) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/jtcps1_fbrd.sv
// Frame-buffer line reader: prefetches one line from SDRAM into a line bank while
// the other bank is scanned out. Optional counter: `define JTCPS1_FBRD_STATS_EN.
module jtcps1_fbrd
  import jtcps1_fbrd_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int AW     = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pxl_cen,
  input  logic             hs,
  input  logic [8:0]       vrender,
  input  logic [8:0]       hdump,
  input  logic             LHBL,
  input  logic             LVBL,
  output logic [AW-1:0]    fbrd_addr,
  output logic             fbrd_cs,
  input  logic             fbrd_ok,
  input  logic [15:0]      fbrd_data,
  output logic [PXL_W-1:0] pix,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);

  state_t           state_q, state_d;
  logic             hs_q;
  logic [8:0]       fetch_line_q, fetch_line_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             wr_bank_q, wr_bank_d;
  logic             underrun_q, underrun_d;
  logic             vis_q, vis_d;

  logic             hs_rise;
  logic             we;
  logic             last;
  logic             abort;
  logic [COL_W-1:0] rd_addr;
  logic [PXL_W-1:0] rd_data;
  logic             unused_data;

  assign unused_data = ^fbrd_data[15:PXL_W];

  always_comb begin
    hs_rise      = hs & ~hs_q;
    we           = (state_q == REQ) & fbrd_ok;
    last         = (col_q == LAST_COL);
    // The last column's write landing on the hs edge counts as a finished line.
    abort        = hs_rise & (state_q != IDLE) & ~(we & last);

    state_d      = state_q;
    col_d        = col_q;
    fetch_line_d = fetch_line_q;
    wr_bank_d    = wr_bank_q;
    underrun_d   = abort;

    case (state_q)
      REQ: begin
        if (fbrd_ok) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = WAIT;
          end
        end
      end
      WAIT:    state_d = REQ;
      default: state_d = state_q;
    endcase

    if (hs_rise) begin
      wr_bank_d    = ~wr_bank_q;
      fetch_line_d = vrender;
      col_d        = '0;
      state_d      = REQ;
    end

    vis_d   = pxl_cen ? (LHBL & LVBL & (hdump <= LAST_COL)) : vis_q;
    rd_addr = (hdump <= LAST_COL) ? hdump : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hs_q         <= 1'b0;
      fetch_line_q <= '0;
      col_q        <= '0;
      wr_bank_q    <= 1'b0;
      underrun_q   <= 1'b0;
      vis_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      hs_q         <= hs;
      fetch_line_q <= fetch_line_d;
      col_q        <= col_d;
      wr_bank_q    <= wr_bank_d;
      underrun_q   <= underrun_d;
      vis_q        <= vis_d;
    end
  end

  assign fbrd_cs   = (state_q == REQ);
  assign fbrd_addr = AW'({fetch_line_q, col_q});
  assign underrun  = underrun_q;
  assign pix       = vis_q ? rd_data : '0;

`ifdef JTCPS1_FBRD_STATS_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (abort && cnt_q != 8'hff) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign underrun_cnt = cnt_q;
`else
  assign underrun_cnt = 8'd0;
`endif

  // Reads always target the bank opposite the one being filled.
  jtcps1_fbrd_linebuf #(
    .LINE_W (LINE_W)
  ) u_linebuf (
    .clk     (clk),
    .wr_bank (wr_bank_q),
    .wr_col  (col_q),
    .wr_data (fbrd_data[PXL_W-1:0]),
    .we      (we),
    .rd_bank (~wr_bank_q),
    .rd_addr (rd_addr),
    .rd_cen  (pxl_cen),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_jtcps1_fbrd.sv
// Directed bench for jtcps1_fbrd with a line-level reference model and an SDRAM slot model.
module tb_jtcps1_fbrd;

  localparam int LW = 384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        hs = 1'b0;
  logic [8:0]  vrender = '0;
  logic [8:0]  hdump = '0;
  logic        LHBL = 1'b0;
  logic        LVBL = 1'b0;
  logic [17:0] fbrd_addr;
  logic        fbrd_cs;
  logic        fbrd_ok = 1'b0;
  logic [15:0] fbrd_data = '0;
  logic [8:0]  pix;
  logic        underrun;
  logic [7:0]  underrun_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jtcps1_fbrd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pxl_cen      (pxl_cen),
    .hs           (hs),
    .vrender      (vrender),
    .hdump        (hdump),
    .LHBL         (LHBL),
    .LVBL         (LVBL),
    .fbrd_addr    (fbrd_addr),
    .fbrd_cs      (fbrd_cs),
    .fbrd_ok      (fbrd_ok),
    .fbrd_data    (fbrd_data),
    .pix          (pix),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SDRAM slot: ok arrives once the same address has been requested for lat clocks.
  int          lat = 3;
  int          sd_cnt = 0;
  logic [17:0] sd_addr_q = '0;
  always @(posedge clk) begin : sdram
    int n;
    if (fbrd_cs) n = (fbrd_addr == sd_addr_q) ? sd_cnt + 1 : 1;
    else n = 0;
    sd_cnt    <= n;
    sd_addr_q <= fbrd_addr;
    fbrd_ok   <= fbrd_cs && (n == lat);
    fbrd_data <= 16'h100 + {7'd0, fbrd_addr[8:0]};
  end

  // Reference model: which bank is filling, which line/column is expected next,
  // what each bank holds, and what pix/underrun must be after every edge.
  logic [8:0] m_bank [2][LW];
  bit         m_valid [2][LW];
  bit         m_hs, m_wrb, m_fetch, m_evt, exp_under, pix_known;
  int         m_line, m_col, m_cnt, line_reqs, last_wr_addr;
  logic [8:0] exp_pix;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hs = 0; m_wrb = 0; m_fetch = 0; m_evt = 0; exp_under = 0;
      m_line = 0; m_col = 0; m_cnt = 0;
      exp_pix = '0; pix_known = 1;
    end else begin
      bit rdb;
      rdb = ~m_wrb;
      m_evt = 0;
      exp_under = 0;
      if (pxl_cen) begin
        if (LHBL && LVBL && hdump < LW) begin
          pix_known = m_valid[rdb][hdump];
          exp_pix = m_bank[rdb][hdump];
        end else begin
          pix_known = 1;
          exp_pix = '0;
        end
      end
      if (fbrd_cs && fbrd_ok) begin
        m_evt = 1;
        check("wr_addr", int'(fbrd_addr), m_fetch ? m_line * 512 + m_col : -1);
        last_wr_addr = int'(fbrd_addr);
        if (m_fetch) begin
          m_bank[m_wrb][m_col] = fbrd_data[8:0];
          m_valid[m_wrb][m_col] = 1;
          m_col++;
          line_reqs++;
          if (m_col == LW) begin
            m_fetch = 0;
            m_col = LW - 1;
          end
        end
      end
      if (hs && !m_hs) begin
        m_evt = 1;
        if (m_fetch) begin
          exp_under = 1;
          if (m_cnt < 255) m_cnt++;
        end
        m_wrb = ~m_wrb;
        m_line = int'(vrender);
        m_col = 0;
        m_fetch = 1;
        line_reqs = 0;
      end
      m_hs = hs;
    end
  end

  // Per-cycle comparison against the model.
  bit          prev_cs = 0;
  logic [17:0] prev_addr = '0;
  int          n_pulse = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      check("underrun", int'(underrun), int'(exp_under));
      if (pix_known) check("pix", int'(pix), int'(exp_pix));
`ifdef JTCPS1_FBRD_STATS_EN
      check("underrun_cnt", int'(underrun_cnt), m_cnt);
`else
      check("underrun_cnt", int'(underrun_cnt), 0);
`endif
      if (!m_fetch) check("cs_idle", int'(fbrd_cs), 0);
      if (prev_cs && fbrd_cs && !m_evt) check("addr_hold", int'(fbrd_addr), int'(prev_addr));
      if (underrun) n_pulse++;
    end
    prev_cs = fbrd_cs;
    prev_addr = fbrd_addr;
  end

  bit vid_auto = 0;

  task automatic tick();
    @(negedge clk);
    if (vid_auto) begin
      if (pxl_cen) hdump = hdump + 9'd1;
      pxl_cen = ~pxl_cen;
      LHBL = (hdump < LW);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int i = 0;
    while (m_fetch && i < maxc) begin
      tick();
      i++;
    end
    check(name, int'(m_fetch), 0);
  endtask

  task automatic pix_probe(input string name, input int col, input bit hb, input int exp);
    hdump = 9'(col);
    LHBL = hb;
    pxl_cen = 1;
    tick();
    pxl_cen = 0;
    check(name, int'(pix), exp);
  endtask

  initial begin
    int i, p0;
    ticks(5);
    rst_n = 1;
    ticks(5);
    check("rst_cs", int'(fbrd_cs), 0);
    check("rst_pix", int'(pix), 0);
    check("rst_cnt", int'(underrun_cnt), 0);
    check("rst_addr", int'(fbrd_addr), 0);
    check("rst_under", int'(underrun), 0);

    // Full line 20 at latency 3.
    hs = 1; vrender = 9'd20;
    tick();
    check("line20_first_addr", int'(fbrd_addr), 20 * 512);
    check("line20_first_cs", int'(fbrd_cs), 1);
    ticks(7);
    hs = 0;
    wait_idle("line20_timeout", 5000);
    check("line20_reqs", line_reqs, 384);
    check("line20_last_addr", last_wr_addr, 20 * 512 + 383);
    ticks(10);
    check("line20_idle_cs", int'(fbrd_cs), 0);
    check("line20_no_under", n_pulse, 0);

    // Next line: line 20 bank becomes readable.
    hs = 1; vrender = 9'd21;
    ticks(5);
    hs = 0;
    LVBL = 1;
    pix_probe("pix_h5", 5, 1, 9'h105);
    ticks(3);
    check("pix_hold", int'(pix), 9'h105);
    pix_probe("pix_hblank", 5, 0, 0);
    pix_probe("pix_h383", 383, 1, 9'h07f);
    pix_probe("pix_h0", 0, 1, 9'h100);
    pix_probe("pix_h400", 400, 1, 0);
    LVBL = 0;
    pix_probe("pix_vblank", 5, 1, 0);
    LVBL = 1;
    hdump = 0;
    vid_auto = 1;
    ticks(1200);
    wait_idle("line21_timeout", 5000);

    // hs edge on the same clock as the last column's ok.
    hs = 1; vrender = 9'd30;
    ticks(4);
    hs = 0;
    i = 0;
    while (!(fbrd_cs && fbrd_ok && fbrd_addr[8:0] == 9'd383) && i < 6000) begin
      tick();
      i++;
    end
    check("coinc_found", int'(fbrd_cs && fbrd_ok && fbrd_addr[8:0] == 9'd383), 1);
    p0 = n_pulse;
    hs = 1; vrender = 9'd31;
    tick();
    check("coinc_under", int'(underrun), 0);
    check("coinc_addr", int'(fbrd_addr), 31 * 512);
    ticks(4);
    hs = 0;
    wait_idle("line31_timeout", 5000);
    check("coinc_pulses", n_pulse - p0, 0);
    hs = 1; vrender = 9'd32;
    ticks(4);
    hs = 0;
    vid_auto = 0;
    pix_probe("coinc_col383", 383, 1, 9'h07f);
    vid_auto = 1;
    wait_idle("line32_timeout", 5000);

    // Reset in the middle of a fetch.
    hs = 1; vrender = 9'd40;
    ticks(4);
    hs = 0;
    i = 0;
    while (!(fbrd_cs && fbrd_addr[8:0] == 9'd100) && i < 2000) begin
      tick();
      i++;
    end
    check("rst_mid_found", int'(fbrd_addr), 40 * 512 + 100);
    rst_n = 0;
    #1;
    check("rst_mid_cs", int'(fbrd_cs), 0);
    check("rst_mid_addr", int'(fbrd_addr), 0);
    check("rst_mid_pix", int'(pix), 0);
    ticks(3);
    rst_n = 1;
    ticks(3);
    hs = 1; vrender = 9'd41;
    tick();
    check("rst_refetch_addr", int'(fbrd_addr), 41 * 512);
    ticks(4);
    hs = 0;
    wait_idle("line41_timeout", 5000);

    // Slow SDRAM: every line overruns.
    lat = 20;
    p0 = n_pulse;
    hs = 1; vrender = 9'd50;
    ticks(8);
    hs = 0;
    ticks(992);
    check("ur_line0", n_pulse - p0, 0);
    for (int k = 0; k < 2; k++) begin
      i = n_pulse;
      hs = 1; vrender = 9'(51 + k);
      ticks(8);
      hs = 0;
      ticks(992);
      check("ur_per_line", n_pulse - i, 1);
    end
    for (int k = 0; k < 260; k++) begin
      hs = 1; vrender = 9'(k);
      ticks(3);
      hs = 0;
      ticks(27);
    end
    ticks(5);
    check("ur_total", n_pulse - p0, 262);
`ifdef JTCPS1_FBRD_STATS_EN
    check("ucnt_final", int'(underrun_cnt), 255);
`else
    check("ucnt_final", int'(underrun_cnt), 0);
`endif
    lat = 3;
    ticks(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
